// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4:1 mux scan/capture block.
// Optional compare feature in the top is guarded by MUX_SCAN_CHECK_EN.
`timescale 1ns/1ps
package mux_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_e;

    localparam int NUM_SEL = 4;
    localparam int SEL_W   = 2;

    // True when the select has reached the final mux input.
    function automatic logic is_last_sel(input logic [SEL_W-1:0] sel);
        return sel == SEL_W'(NUM_SEL - 1);
    endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter: runs 0..DWELL-1 while enabled, wraps to 0, and flags the
// final cycle of each hold with `last`.
`timescale 1ns/1ps
module scan_dwell_counter #(
    parameter int DWELL = 4
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic clr,
    output logic last
);

    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

    logic [CW-1:0] count;

    // With DWELL=1 the count is pinned at 0, so every enabled cycle is last.
    assign last = (count == LAST_CNT);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (last) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mux_scan_capture.sv
// Steps the mux select through every code, samples Y at the end of each
// dwell and publishes the rebuilt word on Q. Define MUX_SCAN_CHECK_EN to add EXP/MISMATCH.
`timescale 1ns/1ps
module mux_scan_capture
    import mux_scan_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               START,
    input  logic               Y,
    output logic [SEL_W-1:0]   C,
    output logic               BUSY,
    output logic [NUM_SEL-1:0] Q,
    output logic               VALID,
    output state_e             dbg_state
`ifdef MUX_SCAN_CHECK_EN
    ,
    input  logic [NUM_SEL-1:0] EXP,
    output logic               MISMATCH
`endif
);

    // Handshake: START is a level request honoured only on an edge where the
    // FSM is IDLE; VALID is a single-cycle strobe qualifying the new Q.

    state_e               state, state_next;
    logic [SEL_W-1:0]     c_next;
    logic [NUM_SEL-2:0]   acc, acc_next;
    logic [NUM_SEL-1:0]   q_next;
    logic                 valid_next;
    logic                 dwell_last;

    scan_dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (state == SCAN),
        .clr   (state == IDLE),
        .last  (dwell_last)
    );

    always_comb begin
        state_next = state;
        c_next     = C;
        acc_next   = acc;
        q_next     = Q;
        valid_next = 1'b0;

        case (state)
            IDLE: begin
                c_next   = '0;
                acc_next = '0;
                if (START) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (dwell_last) begin
                    if (is_last_sel(C)) begin
                        // Final sample goes straight into Q so no partial word is ever visible.
                        q_next     = {Y, acc};
                        valid_next = 1'b1;
                        acc_next   = '0;
                        c_next     = '0;
                        state_next = IDLE;
                    end else begin
                        case (C)
                            2'd0:    acc_next[0] = Y;
                            2'd1:    acc_next[1] = Y;
                            default: acc_next[2] = Y;
                        endcase
                        c_next = C + SEL_W'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
                c_next     = '0;
                acc_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
            C     <= '0;
            acc   <= '0;
            Q     <= '0;
            VALID <= 1'b0;
        end else begin
            state <= state_next;
            C     <= c_next;
            acc   <= acc_next;
            Q     <= q_next;
            VALID <= valid_next;
        end
    end

    assign BUSY      = (state == SCAN);
    assign dbg_state = state;

`ifdef MUX_SCAN_CHECK_EN
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            MISMATCH <= 1'b0;
        end else if (valid_next) begin
            MISMATCH <= (q_next != EXP);
        end
    end
`endif

endmodule

// File: tb/tb_mux_scan_capture.sv
// Directed bench for mux_scan_capture: one DUT at DWELL=4 and one at DWELL=1,
// each behind a gate-level 4:1 mux driven from bench-owned X words.
`timescale 1ns/1ps
module tb_mux_scan_capture;
    import mux_scan_pkg::*;

    logic clk;
    logic rst_n;

    logic [3:0] x4, q4;
    logic [1:0] c4;
    logic       start4, y4, busy4, valid4;
    state_e     st4;

    logic [3:0] x1, q1;
    logic [1:0] c1;
    logic       start1, y1, busy1, valid1;
    state_e     st1;

`ifdef MUX_SCAN_CHECK_EN
    logic [3:0] exp4, exp1;
    logic       mis4, mis1;
`endif

    int n_checks;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign y4 = (~c4[1] & ~c4[0] & x4[0]) | (~c4[1] & c4[0] & x4[1]) |
                ( c4[1] & ~c4[0] & x4[2]) | ( c4[1] & c4[0] & x4[3]);
    assign y1 = (~c1[1] & ~c1[0] & x1[0]) | (~c1[1] & c1[0] & x1[1]) |
                ( c1[1] & ~c1[0] & x1[2]) | ( c1[1] & c1[0] & x1[3]);

    mux_scan_capture #(.DWELL(4)) u_dut4 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start4),
        .Y         (y4),
        .C         (c4),
        .BUSY      (busy4),
        .Q         (q4),
        .VALID     (valid4),
        .dbg_state (st4)
`ifdef MUX_SCAN_CHECK_EN
        ,
        .EXP       (exp4),
        .MISMATCH  (mis4)
`endif
    );

    mux_scan_capture #(.DWELL(1)) u_dut1 (
        .CLK       (clk),
        .RST_N     (rst_n),
        .START     (start1),
        .Y         (y1),
        .C         (c1),
        .BUSY      (busy1),
        .Q         (q1),
        .VALID     (valid1),
        .dbg_state (st1)
`ifdef MUX_SCAN_CHECK_EN
        ,
        .EXP       (exp1),
        .MISMATCH  (mis1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int valid_seen;
        int bad_idle;
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        n_checks++;
        if (c4 !== 2'd0 || busy4 !== 1'b0 || q4 !== 4'd0 || valid4 !== 1'b0 || st4 !== IDLE)
            $display("FAIL reset_dut4: c=%0d busy=%b q=%b valid=%b, required 0/0/0000/0", c4, busy4, q4, valid4);
        else n_pass++;
        n_checks++;
        if (c1 !== 2'd0 || busy1 !== 1'b0 || q1 !== 4'd0 || valid1 !== 1'b0)
            $display("FAIL reset_dut1: c=%0d busy=%b q=%b valid=%b, required 0/0/0000/0", c1, busy1, q1, valid1);
        else n_pass++;
        valid_seen = 0;
        bad_idle   = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid4 || valid1) valid_seen++;
            if (c4 !== 2'd0 || busy4 !== 1'b0 || q4 !== 4'd0) bad_idle++;
        end
        n_checks++;
        if (valid_seen != 0) $display("FAIL idle_valid: %0d pulses, required 0", valid_seen);
        else n_pass++;
        n_checks++;
        if (bad_idle != 0) $display("FAIL idle_outputs: %0d bad cycles, required 0", bad_idle);
        else n_pass++;
    endtask

    task automatic test_scan_dwell4();
        logic [1:0] exp_c;
        x4     = 4'b1010;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int j = 0; j < 16; j++) begin
            exp_c = 2'(j / 4);
            n_checks++;
            if (c4 !== exp_c || busy4 !== 1'b1 || valid4 !== 1'b0)
                $display("FAIL scan4_step%0d: c=%0d busy=%b valid=%b, required c=%0d busy=1 valid=0",
                         j, c4, busy4, valid4, exp_c);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (valid4 !== 1'b1 || q4 !== 4'b1010)
            $display("FAIL scan4_done: valid=%b q=%b, required valid=1 q=1010", valid4, q4);
        else n_pass++;
        n_checks++;
        if (busy4 !== 1'b0 || c4 !== 2'd0 || st4 !== IDLE)
            $display("FAIL scan4_idle: busy=%b c=%0d, required busy=0 c=0", busy4, c4);
        else n_pass++;
        tick();
        n_checks++;
        if (valid4 !== 1'b0 || q4 !== 4'b1010)
            $display("FAIL scan4_hold: valid=%b q=%b, required valid=0 q=1010", valid4, q4);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        x4     = 4'd0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            repeat (15) tick();
            n_checks++;
            if (valid4 !== 1'b0 || busy4 !== 1'b1)
                $display("FAIL b2b_pre%0d: valid=%b busy=%b, required 0/1", i, valid4, busy4);
            else n_pass++;
            tick();
            n_checks++;
            if (valid4 !== 1'b1 || q4 !== 4'(i))
                $display("FAIL b2b_q%0d: valid=%b q=%b, required valid=1 q=%b", i, valid4, q4, 4'(i));
            else n_pass++;
            if (i < 15) begin
                x4     = 4'(i + 1);
                start4 = 1'b1;
            end
            tick();
            start4 = 1'b0;
            n_checks++;
            if (busy4 !== ((i < 15) ? 1'b1 : 1'b0))
                $display("FAIL b2b_busy%0d: busy=%b, required %b", i, busy4, (i < 15) ? 1'b1 : 1'b0);
            else n_pass++;
        end
    endtask

    task automatic test_dwell1();
        x1 = 4'b0110;
`ifdef MUX_SCAN_CHECK_EN
        exp1 = 4'b0110;
`endif
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int j = 0; j < 4; j++) begin
            n_checks++;
            if (c1 !== 2'(j) || busy1 !== 1'b1 || valid1 !== 1'b0)
                $display("FAIL dwell1_step%0d: c=%0d busy=%b valid=%b, required c=%0d busy=1 valid=0",
                         j, c1, busy1, valid1, j);
            else n_pass++;
            tick();
        end
        n_checks++;
        if (valid1 !== 1'b1 || q1 !== 4'b0110 || busy1 !== 1'b0)
            $display("FAIL dwell1_done: valid=%b q=%b busy=%b, required 1/0110/0", valid1, q1, busy1);
        else n_pass++;
`ifdef MUX_SCAN_CHECK_EN
        n_checks++;
        if (mis1 !== 1'b0) $display("FAIL dwell1_mismatch: got %b, required 0", mis1);
        else n_pass++;
`endif
    endtask

    task automatic test_start_ignored_reset();
        int valid_seen;
        int busy_seen;
        x4     = 4'b0101;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (4) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (c4 !== 2'd2 || busy4 !== 1'b1)
            $display("FAIL midscan_start: c=%0d busy=%b, required c=2 busy=1", c4, busy4);
        else n_pass++;
        n_checks++;
        if (q4 !== 4'd15) $display("FAIL midscan_qhold: q=%b, required 1111", q4);
        else n_pass++;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q4 !== 4'd0 || c4 !== 2'd0 || busy4 !== 1'b0 || valid4 !== 1'b0)
            $display("FAIL midscan_reset: q=%b c=%0d busy=%b valid=%b, required 0000/0/0/0", q4, c4, busy4, valid4);
        else n_pass++;
        tick();
        rst_n      = 1'b1;
        valid_seen = 0;
        busy_seen  = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (valid4) valid_seen++;
            if (busy4) busy_seen++;
        end
        n_checks++;
        if (valid_seen != 0 || busy_seen != 0)
            $display("FAIL post_reset_quiet: valid pulses=%0d busy cycles=%0d, required 0/0", valid_seen, busy_seen);
        else n_pass++;
    endtask

`ifdef MUX_SCAN_CHECK_EN
    task automatic test_check_en();
        x4     = 4'b1100;
        exp4   = 4'b1100;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (16) tick();
        n_checks++;
        if (valid4 !== 1'b1 || mis4 !== 1'b0)
            $display("FAIL check_match: valid=%b mismatch=%b, required 1/0", valid4, mis4);
        else n_pass++;
        exp4   = 4'b1101;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (16) tick();
        n_checks++;
        if (valid4 !== 1'b1 || mis4 !== 1'b1)
            $display("FAIL check_miss: valid=%b mismatch=%b, required 1/1", valid4, mis4);
        else n_pass++;
        exp4 = 4'b1100;
        repeat (3) tick();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        repeat (15) tick();
        n_checks++;
        if (mis4 !== 1'b1) $display("FAIL check_hold: mismatch=%b, required 1", mis4);
        else n_pass++;
        tick();
        n_checks++;
        if (valid4 !== 1'b1 || mis4 !== 1'b0)
            $display("FAIL check_clear: valid=%b mismatch=%b, required 1/0", valid4, mis4);
        else n_pass++;
    endtask
`endif

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start4   = 1'b0;
        start1   = 1'b0;
        x4       = 4'd0;
        x1       = 4'd0;
`ifdef MUX_SCAN_CHECK_EN
        exp4     = 4'd0;
        exp1     = 4'd0;
`endif
        test_reset();
        test_scan_dwell4();
        test_back_to_back();
        test_dwell1();
        test_start_ignored_reset();
`ifdef MUX_SCAN_CHECK_EN
        test_check_en();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
